// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types and elaboration helpers for the reset sequencer:
//               FSM state encoding, per-stage delay field extraction and
//               counter width sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // Sequencer states, 3-bit encoded
    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_DLY    = 3'd1,
        ST_ACK    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } seq_state_t;

    // Upper bound on sequenced stages (idx and err_stage are 3 bits)
    localparam int c_MAX_STAGE = 8;
    // Width of the zero-extended delay vector handed to the helpers below
    localparam int c_VEC_W     = 256;

    // Extract delay field idx (dly_w bits wide, stage 0 in the LSBs)
    function automatic longint unsigned dly_field(
        input logic [c_VEC_W-1:0] vec,
        input int                 dly_w,
        input int                 idx
    );
        longint unsigned r;
        r = 0;
        for (int b = 0; b < dly_w && b < 64; b++) begin
            if ((idx * dly_w + b) < c_VEC_W) begin
                r[b] = vec[idx * dly_w + b];
            end
        end
        return r;
    endfunction

    // Counter width able to hold the largest terminal value of any phase
    function automatic int calc_cnt_w(
        input longint unsigned    hold,
        input logic [c_VEC_W-1:0] vec,
        input int                 dly_w,
        input int                 n_stage,
        input longint unsigned    tmo
    );
        longint unsigned m;
        m = hold;
        if (tmo > m) begin
            m = tmo;
        end
        for (int i = 0; i < n_stage; i++) begin
            if (dly_field(vec, dly_w, i) > m) begin
                m = dly_field(vec, dly_w, i);
            end
        end
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_tmr.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_tmr
// Description : Up-counter with synchronous clear and terminal-count compare.
//               Stops (saturates) at the terminal value so it never wraps.
//               One instance serves the hold, delay and timeout phases.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_tmr
    import rst_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [CNT_W-1:0] i_tc,
    output logic                  o_at_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_at_tc = (r_cnt == i_tc);

    // Count up while enabled; hold at the terminal value until cleared
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_at_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Power-up / soft-reset sequencer. Holds all block resets,
//               then releases them one at a time in index order, each after
//               its own delay and gated by that stage's ack, with optional
//               ack timeout and ack-loss monitoring once fully released.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned                N_STAGE   = 3,
    parameter int unsigned                HOLD_CYC  = 16,
    parameter int unsigned                DLY_W     = 16,
    parameter logic [N_STAGE*DLY_W-1:0]   STAGE_DLY = {16'd2, 16'd0, 16'd8},
    parameter int unsigned                TMO_CYC   = 1024,
    parameter logic [N_STAGE-1:0]         ACK_MON   = 3'b001
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               soft_rst_req,
    input  wire logic [N_STAGE-1:0] stage_ack,
    output logic      [N_STAGE-1:0] stage_rst,
    output logic                    busy,
    output logic                    seq_done,
    output logic                    seq_err,
    output logic      [2:0]         err_stage
);

    localparam logic [c_VEC_W-1:0] c_STAGE_DLY_EXT = c_VEC_W'(STAGE_DLY);
    localparam int                 c_CNT_W = calc_cnt_w(HOLD_CYC, c_STAGE_DLY_EXT,
                                                        DLY_W, N_STAGE, TMO_CYC);
    // Hold terminal is HOLD_CYC: the forcing edge itself loads cnt=0, so
    // HOLD_CYC further edges elapse before sequencing starts.
    localparam logic [c_CNT_W-1:0] c_HOLD_TC = c_CNT_W'(HOLD_CYC);
    // With no timeout the counter simply parks at all-ones, never consumed
    localparam logic [c_CNT_W-1:0] c_TMO_TC  = (TMO_CYC == 0) ? {c_CNT_W{1'b1}}
                                                              : c_CNT_W'(TMO_CYC - 1);
    localparam logic [2:0]         c_LAST    = 3'(N_STAGE - 1);
    localparam logic [7:0]         c_ACK_MON = 8'(ACK_MON);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [N_STAGE-1:0] r_stage_rst;
    logic [N_STAGE-1:0] w_stage_rst_nxt;
    logic               r_busy;
    logic               r_seq_done;
    logic               r_seq_err;
    logic [2:0]         r_err_stage;
    logic [2:0]         w_err_stage_nxt;

    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic [c_CNT_W-1:0] w_tmr_tc;
    logic               w_at_tc;
    logic [7:0]         w_ack_ext;
    logic               w_mon_lost;

    logic [c_CNT_W-1:0] w_dly_tc [c_MAX_STAGE];

    assign w_ack_ext  = 8'(stage_ack);
    assign w_mon_lost = |(~w_ack_ext & c_ACK_MON);

    // Per-stage delay terminal: a zero delay still spends one cycle in DLY
    for (genvar gi = 0; gi < c_MAX_STAGE; gi++) begin : g_dly_tc
        if (gi < N_STAGE) begin : g_used
            localparam longint unsigned c_DLY = dly_field(c_STAGE_DLY_EXT, DLY_W, gi);
            assign w_dly_tc[gi] = (c_DLY == 0) ? '0 : c_CNT_W'(c_DLY - 1);
        end else begin : g_unused
            assign w_dly_tc[gi] = '0;
        end
    end

    rst_seq_tmr #(
        .CNT_W   (c_CNT_W)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_tc    (w_tmr_tc),
        .o_at_tc (w_at_tc)
    );

    // Next-state, index, timer control and next output values
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b1;
        w_tmr_tc        = c_HOLD_TC;
        w_stage_rst_nxt = '1;
        w_err_stage_nxt = 3'd0;

        case (r_state)
            ST_ASSERT: w_tmr_tc = c_HOLD_TC;
            ST_DLY:    w_tmr_tc = w_dly_tc[r_idx];
            ST_ACK:    w_tmr_tc = c_TMO_TC;
            default: begin
                w_tmr_tc = '0;
                w_tmr_en = 1'b0;
            end
        endcase

        if (soft_rst_req) begin
            w_state_nxt = ST_ASSERT;
            w_idx_nxt   = 3'd0;
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (w_at_tc) begin
                        w_state_nxt = ST_DLY;
                        w_idx_nxt   = 3'd0;
                        w_tmr_clr   = 1'b1;
                    end
                end
                ST_DLY: begin
                    if (w_at_tc) begin
                        w_state_nxt = ST_ACK;
                        w_tmr_clr   = 1'b1;
                    end
                end
                ST_ACK: begin
                    // Ack wins over a timeout landing on the same cycle
                    if (w_ack_ext[r_idx]) begin
                        w_tmr_clr = 1'b1;
                        if (r_idx == c_LAST) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_DLY;
                            w_idx_nxt   = r_idx + 3'd1;
                        end
                    end else if ((TMO_CYC != 0) && w_at_tc) begin
                        w_state_nxt = ST_ERR;
                        w_tmr_clr   = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_mon_lost) begin
                        w_state_nxt = ST_ASSERT;
                        w_idx_nxt   = 3'd0;
                        w_tmr_clr   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        // Stages below idx are released; the current stage releases on DLY exit
        for (int j = 0; j < int'(N_STAGE); j++) begin
            case (w_state_nxt)
                ST_DONE: w_stage_rst_nxt[j] = 1'b0;
                ST_DLY:  w_stage_rst_nxt[j] = (j >= int'(w_idx_nxt));
                ST_ACK:  w_stage_rst_nxt[j] = (j > int'(w_idx_nxt));
                default: w_stage_rst_nxt[j] = 1'b1;
            endcase
        end

        if (w_state_nxt == ST_ERR) begin
            w_err_stage_nxt = w_idx_nxt;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ASSERT;
            r_idx       <= 3'd0;
            r_stage_rst <= '1;
            r_busy      <= 1'b1;
            r_seq_done  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_stage <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_stage_rst <= w_stage_rst_nxt;
            r_busy      <= (w_state_nxt != ST_DONE) && (w_state_nxt != ST_ERR);
            r_seq_done  <= (w_state_nxt == ST_DONE);
            r_seq_err   <= (w_state_nxt == ST_ERR);
            r_err_stage <= w_err_stage_nxt;
        end
    end

    assign stage_rst = r_stage_rst;
    assign busy      = r_busy;
    assign seq_done  = r_seq_done;
    assign seq_err   = r_seq_err;
    assign err_stage = r_err_stage;

endmodule
`default_nettype wire
